serial_loader: RTL and testbench

SERIAL_LOADER -- requirements
Module: serial_loader

---
 rtl/serial_loader.sv | 161 ++++++++++++++++
 tb/tb_serial_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_loader.sv
// Serial (8N1) boot loader: assembles little-endian words from a UART
// stream and writes them to consecutive word addresses on a simple bus.
module serial_loader #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [31:0] LOAD_BASE    = 32'h1000,
  parameter int          WORDS        = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  output logic        enable,
  output logic        rw,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        done,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   LAST    = 16'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic          rx1_q, rx1_d;
  logic          rx2_q, rx2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    pos_q, pos_d;
  logic [31:0]   word_q, word_d;
  logic [15:0]   idx_q, idx_d;
  logic          en_q, en_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          accept;

  always_comb begin
    state_d = state_q;
    rx1_d   = rxd;
    rx2_d   = rx1_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pos_d   = pos_q;
    word_d  = word_q;
    idx_d   = idx_q;
    en_d    = 1'b0;
    addr_d  = 32'h0;
    data_d  = 32'h0;
    done_d  = done_q;
    ferr_d  = ferr_q;
    accept  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx2_q && !done_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = rx2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          // a frame finishing after the last write is ignored entirely
          if (!done_q) begin
            if (rx2_q) accept = 1'b1;
            else       ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      word_d[{pos_q, 3'b000} +: 8] = shift_q;
      pos_d = pos_q + 2'd1;
      if (pos_q == 2'd3) begin
        en_d   = 1'b1;
        addr_d = LOAD_BASE + {16'h0, idx_q};
        data_d = {shift_q, word_q[23:0]};
      end
    end

    if (en_q) begin
      idx_d = idx_q + 16'd1;
      if (idx_q == LAST) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rx1_q   <= 1'b1;
      rx2_q   <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h0;
      pos_q   <= 2'd0;
      word_q  <= 32'h0;
      idx_q   <= 16'h0;
      en_q    <= 1'b0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rx1_q   <= rx1_d;
      rx2_q   <= rx2_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pos_q   <= pos_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign enable    = en_q;
  assign rw        = en_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign done      = done_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader (CLKS_PER_BIT=4, WORDS=2).
module tb_serial_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rxd = 1'b1;
  logic        enable;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] data;
  logic        done;
  logic        frame_err;

  int total = 0;
  int bad = 0;

  int          stb_cnt = 0;
  int          hi_cyc = 0;
  logic [31:0] a_log[0:7];
  logic [31:0] d_log[0:7];
  logic        rw_log[0:7];
  bit          got_en;

  serial_loader #(
    .CLKS_PER_BIT(4),
    .LOAD_BASE(32'h1000),
    .WORDS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .enable(enable),
    .rw(rw),
    .addr(addr),
    .data(data),
    .done(done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // strobe monitor: counts enable-high cycles and logs each strobe
  logic en_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      stb_cnt = 0;
      hi_cyc  = 0;
    end else if (enable) begin
      hi_cyc = hi_cyc + 1;
      if (!en_prev && stb_cnt < 8) begin
        a_log[stb_cnt]  = addr;
        d_log[stb_cnt]  = data;
        rw_log[stb_cnt] = rw;
        stb_cnt = stb_cnt + 1;
      end
    end
    en_prev = enable;
  end

  task automatic chk(input string tag, input logic [67:0] obs,
                     input logic [67:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    @(negedge clk) rxd = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) @(negedge clk);
    end
    rxd = stop;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outs", {enable, rw, addr, data, done, frame_err}, 68'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // one word
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    chk("w1_cnt", 68'(stb_cnt), 68'd1);
    chk("w1_len", 68'(hi_cyc), 68'd1);
    chk("w1_addr", 68'(a_log[0]), 68'h1000);
    chk("w1_data", 68'(d_log[0]), 68'h12345678);
    chk("w1_rw", 68'(rw_log[0]), 68'd1);
    chk("w1_done", 68'(done), 68'd0);
    chk("idle_bus", {enable, rw, addr, data}, 68'h0);

    // two words then done
    do_reset();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    chk("w2_cnt", 68'(stb_cnt), 68'd2);
    chk("w2_len", 68'(hi_cyc), 68'd2);
    chk("w2_a0", 68'(a_log[0]), 68'h1000);
    chk("w2_d0", 68'(d_log[0]), 68'h04030201);
    chk("w2_a1", 68'(a_log[1]), 68'h1001);
    chk("w2_d1", 68'(d_log[1]), 68'h08070605);
    chk("w2_done", 68'(done), 68'd1);
    send_byte(8'h09);
    send_bits(8'h5A, 1'b0);
    chk("post_cnt", 68'(stb_cnt), 68'd2);
    chk("post_done", 68'(done), 68'd1);
    chk("post_ferr", 68'(frame_err), 68'd0);

    // framing error discards byte
    do_reset();
    send_bits(8'hAA, 1'b0);
    chk("fe_flag", 68'(frame_err), 68'd1);
    chk("fe_cnt0", 68'(stb_cnt), 68'd0);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    chk("fe_cnt", 68'(stb_cnt), 68'd1);
    chk("fe_data", 68'(d_log[0]), 68'h12345678);
    chk("fe_sticky", 68'(frame_err), 68'd1);

    // one-cycle glitch is a false start
    do_reset();
    @(negedge clk) rxd = 1'b0;
    @(negedge clk) rxd = 1'b1;
    repeat (20) @(negedge clk);
    chk("gl_ferr", 68'(frame_err), 68'd0);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    chk("gl_cnt", 68'(stb_cnt), 68'd1);
    chk("gl_data", 68'(d_log[0]), 68'h12345678);

    // reset mid-word discards partial word
    do_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    chk("rw_cnt", 68'(stb_cnt), 68'd1);
    chk("rw_addr", 68'(a_log[0]), 68'h1000);
    chk("rw_data", 68'(d_log[0]), 68'h11223344);

    // reset during the strobe cycle
    do_reset();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    got_en = 1'b0;
    fork
      send_byte(8'h04);
      begin
        for (int i = 0; i < 200 && !got_en; i++) begin
          @(negedge clk);
          if (enable) got_en = 1'b1;
        end
        if (got_en) begin
          reset = 1'b1;
          @(posedge clk);
          #1;
          chk("rs_outs", {enable, rw, addr, data, done, frame_err}, 68'h0);
          @(negedge clk) reset = 1'b0;
        end
      end
    join
    chk("rs_seen", 68'(got_en), 68'd1);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    chk("rs_addr", 68'(a_log[0]), 68'h1000);
    chk("rs_data", 68'(d_log[0]), 68'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
